// File: rtl/fir_sample_sequencer.sv
// Key-driven sample sequencer for a 3-bit FIR core. It plays a 16-entry pattern
// by single steps or at a fixed cadence, and can append a run of zero samples.
module fir_sample_sequencer #(
    parameter int STEP_DIV  = 25,
    parameter int FLUSH_LEN = 8
) (
    input  logic       clk_50Hz,
    input  logic       i_rst_n,
    input  logic       i_key_run_n,
    input  logic       i_key_step_n,
    input  logic       i_key_load_n,
    input  logic       i_loop,
    input  logic [2:0] i_manual_x,
    output logic [2:0] o_xin,
    output logic       o_sample_stb,
    output logic [3:0] o_index,
    output logic [1:0] o_state
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t        state;
    logic [2:0]    run_sync, step_sync, load_sync;
    logic          run_ev, step_ev, load_ev;
    logic [2:0]    pattern [16];
    logic [3:0]    wr_ptr, rd_ptr;
    logic [PW-1:0] presc;
    logic [FW-1:0] flush_cnt;
    logic          vld_p1;
    logic          presc_wrap, last_entry, pat_emit, flush_emit;

    // Two synchronizer flops per key plus one history flop for press detection.
    always_ff @(posedge clk_50Hz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_sync  <= '1;
            step_sync <= '1;
            load_sync <= '1;
        end else begin
            run_sync  <= {run_sync[1:0], i_key_run_n};
            step_sync <= {step_sync[1:0], i_key_step_n};
            load_sync <= {load_sync[1:0], i_key_load_n};
        end
    end

    assign run_ev     = run_sync[2] & ~run_sync[1];
    assign step_ev    = step_sync[2] & ~step_sync[1];
    assign load_ev    = load_sync[2] & ~load_sync[1];
    assign presc_wrap = (presc == PRESC_LAST);
    assign last_entry = (rd_ptr == 4'd15) && !i_loop;

    // A run event always wins over a step on the same edge; nothing is emitted
    // while the previous sample's strobe has not yet been raised.
    always_comb begin
        pat_emit = 1'b0;
        if (!vld_p1 && !run_ev) begin
            case (state)
                IDLE, PAUSE: pat_emit = step_ev;
                RUN:         pat_emit = presc_wrap;
                default:     pat_emit = 1'b0;
            endcase
        end
    end

    assign flush_emit = (state == FLUSH) && presc_wrap && !vld_p1;

    always_ff @(posedge clk_50Hz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_xin        <= 3'd0;
            vld_p1       <= 1'b0;
            o_sample_stb <= 1'b0;
            rd_ptr       <= 4'd0;
            wr_ptr       <= 4'd0;
            presc        <= '0;
            flush_cnt    <= '0;
            for (int i = 0; i < 16; i++) begin
                pattern[i] <= (i == 0) ? 3'd7 : 3'd0;
            end
        end else begin
            // Stage 0 -> 1: sample lands on o_xin; stage 1 -> 2: strobe rises a cycle later.
            vld_p1       <= pat_emit | flush_emit;
            o_sample_stb <= vld_p1;

            if (pat_emit) begin
                o_xin  <= pattern[rd_ptr];
                rd_ptr <= rd_ptr + 4'd1;
            end else if (flush_emit) begin
                o_xin <= 3'd0;
            end

            if (load_ev && state == IDLE) begin
                pattern[wr_ptr] <= i_manual_x;
                wr_ptr          <= wr_ptr + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (run_ev) begin
                        state <= RUN;
                        presc <= '0;
                    end else if (pat_emit && last_entry) begin
                        state     <= FLUSH;
                        presc     <= '0;
                        flush_cnt <= '0;
                    end
                end
                RUN: begin
                    if (run_ev) begin
                        state <= PAUSE;
                    end else begin
                        presc <= presc_wrap ? '0 : presc + 1'b1;
                        if (pat_emit && last_entry) begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                        end
                    end
                end
                PAUSE: begin
                    if (run_ev) begin
                        state <= RUN;
                    end else if (pat_emit && last_entry) begin
                        state     <= FLUSH;
                        presc     <= '0;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    presc <= presc_wrap ? '0 : presc + 1'b1;
                    if (flush_emit) begin
                        if (flush_cnt == FLUSH_LAST) begin
                            state     <= IDLE;
                            presc     <= '0;
                            flush_cnt <= '0;
                        end else begin
                            flush_cnt <= flush_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_index = rd_ptr;
    assign o_state = state;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: keys are pressed as levels, strobes are logged
// by a monitor and compared with a pattern/pointer model and cadence arithmetic.
module tb_fir_sample_sequencer;

    localparam int STEP_DIV  = 25;
    localparam int FLUSH_LEN = 8;
    localparam int K_RUN     = 1;
    localparam int K_STEP    = 2;
    localparam int K_LOAD    = 4;

    logic       clk_50Hz     = 1'b0;
    logic       i_rst_n      = 1'b0;
    logic       i_key_run_n  = 1'b1;
    logic       i_key_step_n = 1'b1;
    logic       i_key_load_n = 1'b1;
    logic       i_loop       = 1'b0;
    logic [2:0] i_manual_x   = 3'd0;
    logic [2:0] o_xin;
    logic       o_sample_stb;
    logic [3:0] o_index;
    logic [1:0] o_state;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   stb_cyc[$];
    int   stb_val[$];
    logic stb_prev = 1'b0;
    int   stb_wide = 0;

    logic [2:0] ref_pat [16];
    int         ref_rd = 0;
    int         ref_wr = 0;

    fir_sample_sequencer #(.STEP_DIV(STEP_DIV), .FLUSH_LEN(FLUSH_LEN)) dut (
        .clk_50Hz     (clk_50Hz),
        .i_rst_n      (i_rst_n),
        .i_key_run_n  (i_key_run_n),
        .i_key_step_n (i_key_step_n),
        .i_key_load_n (i_key_load_n),
        .i_loop       (i_loop),
        .i_manual_x   (i_manual_x),
        .o_xin        (o_xin),
        .o_sample_stb (o_sample_stb),
        .o_index      (o_index),
        .o_state      (o_state)
    );

    always #10 clk_50Hz = ~clk_50Hz;

    always @(posedge clk_50Hz) cyc <= cyc + 1;

    // Log every strobe rising edge with the cycle it was seen in and the sample value.
    always @(negedge clk_50Hz) begin
        if (o_sample_stb === 1'b1 && stb_prev !== 1'b1) begin
            stb_cyc.push_back(cyc);
            stb_val.push_back(int'(o_xin));
        end
        if (o_sample_stb === 1'b1 && stb_prev === 1'b1) stb_wide <= stb_wide + 1;
        stb_prev <= o_sample_stb;
    end

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) ref_pat[i] = (i == 0) ? 3'd7 : 3'd0;
        ref_rd = 0;
        ref_wr = 0;
    endfunction

    function automatic int model_emit();
        int v = int'(ref_pat[ref_rd]);
        ref_rd = (ref_rd + 1) % 16;
        return v;
    endfunction

    function automatic void model_load(input int v);
        ref_pat[ref_wr] = 3'(v);
        ref_wr = (ref_wr + 1) % 16;
    endfunction

    task automatic set_keys(input int mask, input logic v);
        if ((mask & K_RUN) != 0)  i_key_run_n  = v;
        if ((mask & K_STEP) != 0) i_key_step_n = v;
        if ((mask & K_LOAD) != 0) i_key_load_n = v;
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk_50Hz);
            #1;
        end
    endtask

    // Key goes low now; ev is the clock edge on which the press takes effect.
    task automatic press_now(input int mask, output int ev);
        set_keys(mask, 1'b0);
        ev = cyc + 3;
        repeat (3) @(posedge clk_50Hz);
        #1;
        set_keys(mask, 1'b1);
        repeat (2) @(posedge clk_50Hz);
        #1;
    endtask

    task automatic press(input int mask, output int ev);
        @(posedge clk_50Hz);
        #1;
        press_now(mask, ev);
    endtask

    task automatic wait_strobes(input int n, input int budget, output bit ok);
        int k = 0;
        while (stb_cyc.size() < n && k < budget) begin
            @(negedge clk_50Hz);
            #1;
            k++;
        end
        ok = (stb_cyc.size() >= n);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        set_keys(K_RUN | K_STEP | K_LOAD, 1'b1);
        repeat (2) @(posedge clk_50Hz);
        #1;
        stb_cyc.delete();
        stb_val.delete();
        model_reset();
        i_rst_n = 1'b1;
        repeat (2) @(posedge clk_50Hz);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_50Hz);
        @(negedge clk_50Hz);
        tests++; if (o_xin !== 3'd0) begin fails++; $display("FAIL reset_xin: got %0d, expected 0", o_xin); end
        tests++; if (o_sample_stb !== 1'b0) begin fails++; $display("FAIL reset_stb: got %0b, expected 0", o_sample_stb); end
        tests++; if (o_index !== 4'd0) begin fails++; $display("FAIL reset_index: got %0d, expected 0", o_index); end
        tests++; if (o_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d, expected 0", o_state); end
        i_rst_n = 1'b1;
        model_reset();
        repeat (6) @(posedge clk_50Hz);
        #1;
        tests++; if (stb_cyc.size() != 0) begin fails++; $display("FAIL reset_quiet: got %0d strobes, expected 0", stb_cyc.size()); end
        tests++; if (o_state !== 2'd0) begin fails++; $display("FAIL reset_idle: got state %0d, expected 0", o_state); end
    endtask

    task automatic test_step_idle();
        int ev, exp;
        do_reset();
        @(posedge clk_50Hz);
        #1;
        i_key_step_n = 1'b0;
        ev = cyc + 3;
        goto_cycle(ev - 1);
        @(negedge clk_50Hz);
        tests++; if (o_index !== 4'd0) begin fails++; $display("FAIL step_early_index: got %0d, expected 0", o_index); end
        exp = model_emit();
        @(negedge clk_50Hz);
        tests++; if (o_xin !== 3'(exp)) begin fails++; $display("FAIL step_xin: got %0d, expected %0d", o_xin, exp); end
        tests++; if (o_sample_stb !== 1'b0) begin fails++; $display("FAIL step_stb_early: got %0b, expected 0", o_sample_stb); end
        tests++; if (o_index !== 4'(ref_rd)) begin fails++; $display("FAIL step_index: got %0d, expected %0d", o_index, ref_rd); end
        i_key_step_n = 1'b1;
        @(negedge clk_50Hz);
        tests++; if (o_sample_stb !== 1'b1) begin fails++; $display("FAIL step_stb_high: got %0b, expected 1", o_sample_stb); end
        @(negedge clk_50Hz);
        tests++; if (o_sample_stb !== 1'b0) begin fails++; $display("FAIL step_stb_low: got %0b, expected 0", o_sample_stb); end
        tests++; if (o_state !== 2'd0) begin fails++; $display("FAIL step_state: got %0d, expected 0", o_state); end
    endtask

    task automatic test_run_flush();
        int r, k, exp;
        bit seen16;
        do_reset();
        i_loop = 1'b0;
        press(K_RUN, r);
        k = 0;
        seen16 = 1'b0;
        while (stb_cyc.size() < 16 + FLUSH_LEN && k < 700) begin
            @(negedge clk_50Hz);
            #1;
            k++;
            if (!seen16 && stb_cyc.size() == 16) begin
                seen16 = 1'b1;
                tests++; if (o_state !== 2'd3) begin fails++; $display("FAIL flush_entry_state: got %0d, expected 3", o_state); end
            end
        end
        tests++; if (stb_cyc.size() != 16 + FLUSH_LEN) begin fails++; $display("FAIL run_strobe_count: got %0d, expected %0d", stb_cyc.size(), 16 + FLUSH_LEN); end
        tests++; if (o_state !== 2'd0) begin fails++; $display("FAIL flush_exit_state: got %0d, expected 0", o_state); end
        tests++; if (o_index !== 4'd0) begin fails++; $display("FAIL flush_exit_index: got %0d, expected 0", o_index); end
        for (int i = 0; i < stb_cyc.size(); i++) begin
            exp = (i < 16) ? model_emit() : 0;
            tests++; if (stb_val[i] != exp) begin fails++; $display("FAIL run_value[%0d]: got %0d, expected %0d", i, stb_val[i], exp); end
            tests++; if (stb_cyc[i] != r + 1 + STEP_DIV * (i + 1)) begin fails++; $display("FAIL run_cadence[%0d]: got cycle %0d, expected %0d", i, stb_cyc[i], r + 1 + STEP_DIV * (i + 1)); end
        end
        repeat (40) @(posedge clk_50Hz);
        #1;
        tests++; if (stb_cyc.size() != 16 + FLUSH_LEN) begin fails++; $display("FAIL idle_after_flush: got %0d strobes, expected %0d", stb_cyc.size(), 16 + FLUSH_LEN); end
    endtask

    task automatic test_load_step();
        int ev, nload, v, exp;
        int vals[$];
        do_reset();
        i_loop = 1'b1;
        vals = '{5, 2, 6};
        nload = 3 + $urandom_range(0, 3);
        while (vals.size() < nload) vals.push_back($urandom_range(1, 7));
        for (int i = 0; i < nload; i++) begin
            i_manual_x = 3'(vals[i]);
            press(K_LOAD, ev);
            model_load(vals[i]);
        end
        tests++; if (stb_cyc.size() != 0 || o_state !== 2'd0) begin fails++; $display("FAIL load_quiet: got %0d strobes state %0d, expected 0 and 0", stb_cyc.size(), o_state); end
        for (int i = 0; i < nload; i++) begin
            press(K_STEP, ev);
            exp = model_emit();
            tests++; if (stb_val.size() != i + 1 || stb_val[stb_val.size() - 1] != exp) begin fails++; $display("FAIL load_step_value[%0d]: got %0d, expected %0d", i, stb_val[stb_val.size() - 1], exp); end
            tests++; if (stb_cyc[stb_cyc.size() - 1] != ev + 1) begin fails++; $display("FAIL load_step_timing[%0d]: got %0d, expected %0d", i, stb_cyc[stb_cyc.size() - 1], ev + 1); end
        end
        tests++; if (o_index !== 4'(ref_rd)) begin fails++; $display("FAIL load_step_index: got %0d, expected %0d", o_index, ref_rd); end
        press(K_RUN, ev);
        tests++; if (o_state !== 2'd1) begin fails++; $display("FAIL load_run_state: got %0d, expected 1", o_state); end
        v = $urandom_range(1, 7);
        i_manual_x = 3'(v);
        press(K_LOAD, ev);
        press(K_RUN, ev);
        tests++; if (o_state !== 2'd2) begin fails++; $display("FAIL load_pause_state: got %0d, expected 2", o_state); end
        tests++; if (stb_cyc.size() != nload) begin fails++; $display("FAIL load_run_strobes: got %0d, expected %0d", stb_cyc.size(), nload); end
        press(K_STEP, ev);
        exp = model_emit();
        tests++; if (stb_val[stb_val.size() - 1] != exp) begin fails++; $display("FAIL load_in_run_ignored: got %0d, expected %0d", stb_val[stb_val.size() - 1], exp); end
    endtask

    task automatic test_pause_resume();
        int r, ev, p, h, last, e, pc, q, exp;
        bit ok;
        do_reset();
        i_loop = 1'b1;
        press(K_RUN, r);
        wait_strobes(1, 60, ok);
        tests++; if (!ok || stb_cyc[0] != r + STEP_DIV + 1) begin fails++; $display("FAIL pause_first_strobe: got cycle %0d, expected %0d", ok ? stb_cyc[0] : -1, r + STEP_DIV + 1); end
        exp = model_emit();
        tests++; if (stb_val[0] != exp) begin fails++; $display("FAIL pause_first_value: got %0d, expected %0d", stb_val[0], exp); end
        for (int it = 0; it < 2; it++) begin
            p = (it == 0) ? 10 : $urandom_range(3, STEP_DIV - 3);
            h = (it == 0) ? 100 : $urandom_range(30, 120);
            last = stb_cyc.size();
            e = stb_cyc[last - 1] - 1;
            pc = e + 1 + p;
            goto_cycle(pc - 3);
            press_now(K_RUN, ev);
            tests++; if (o_state !== 2'd2) begin fails++; $display("FAIL pause_state[%0d]: got %0d, expected 2", it, o_state); end
            q = pc + h;
            goto_cycle(q - 3);
            tests++; if (stb_cyc.size() != last) begin fails++; $display("FAIL pause_quiet[%0d]: got %0d strobes, expected %0d", it, stb_cyc.size(), last); end
            press_now(K_RUN, ev);
            tests++; if (o_state !== 2'd1) begin fails++; $display("FAIL resume_state[%0d]: got %0d, expected 1", it, o_state); end
            wait_strobes(last + 1, 60, ok);
            exp = q + (STEP_DIV - p) + 1;
            tests++; if (!ok || stb_cyc[last] != exp) begin fails++; $display("FAIL resume_timing[%0d]: got cycle %0d, expected %0d", it, ok ? stb_cyc[last] : -1, exp); end
            exp = model_emit();
            tests++; if (!ok || stb_val[last] != exp) begin fails++; $display("FAIL resume_value[%0d]: got %0d, expected %0d", it, ok ? stb_val[last] : -1, exp); end
        end
    endtask

    task automatic test_loop();
        int r, k, ev, ev2, e40, exp, n;
        bit saw_flush, ok;
        do_reset();
        i_loop = 1'b1;
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin
            exp = $urandom_range(0, 7);
            i_manual_x = 3'(exp);
            press(K_LOAD, ev);
            model_load(exp);
        end
        press(K_RUN, r);
        k = 0;
        saw_flush = 1'b0;
        while (stb_cyc.size() < 40 && k < 40 * STEP_DIV + 60) begin
            @(negedge clk_50Hz);
            #1;
            k++;
            if (o_state === 2'd3) saw_flush = 1'b1;
        end
        tests++; if (stb_cyc.size() != 40) begin fails++; $display("FAIL loop_count: got %0d, expected 40", stb_cyc.size()); end
        tests++; if (saw_flush) begin fails++; $display("FAIL loop_no_flush: got state 3, expected never"); end
        for (int i = 0; i < stb_cyc.size(); i++) begin
            exp = model_emit();
            tests++; if (stb_val[i] != exp) begin fails++; $display("FAIL loop_value[%0d]: got %0d, expected %0d", i, stb_val[i], exp); end
            tests++; if (stb_cyc[i] != r + 1 + STEP_DIV * (i + 1)) begin fails++; $display("FAIL loop_cadence[%0d]: got %0d, expected %0d", i, stb_cyc[i], r + 1 + STEP_DIV * (i + 1)); end
        end
        tests++; if (o_index !== 4'(ref_rd)) begin fails++; $display("FAIL loop_index: got %0d, expected %0d", o_index, ref_rd); end
        e40 = stb_cyc[stb_cyc.size() - 1] - 1;
        press_now(K_RUN | K_STEP, ev);
        tests++; if (o_state !== 2'd2 || stb_cyc.size() != 40) begin fails++; $display("FAIL run_step_pause: got state %0d strobes %0d, expected 2 and 40", o_state, stb_cyc.size()); end
        repeat (20) @(posedge clk_50Hz);
        #1;
        press_now(K_RUN | K_STEP, ev2);
        tests++; if (o_state !== 2'd1 || stb_cyc.size() != 40) begin fails++; $display("FAIL run_step_resume: got state %0d strobes %0d, expected 1 and 40", o_state, stb_cyc.size()); end
        wait_strobes(41, 60, ok);
        exp = ev2 + (STEP_DIV - (ev - e40 - 1)) + 1;
        tests++; if (!ok || stb_cyc[40] != exp) begin fails++; $display("FAIL run_step_next: got cycle %0d, expected %0d", ok ? stb_cyc[40] : -1, exp); end
    endtask

    task automatic test_reset_flush();
        int ev, k, exp;
        do_reset();
        i_loop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp = $urandom_range(1, 7);
            i_manual_x = 3'(exp);
            press(K_LOAD, ev);
            model_load(exp);
        end
        for (int i = 0; i < 16; i++) begin
            press(K_STEP, ev);
            exp = model_emit();
            tests++; if (stb_val[stb_val.size() - 1] != exp) begin fails++; $display("FAIL pass_value[%0d]: got %0d, expected %0d", i, stb_val[stb_val.size() - 1], exp); end
        end
        tests++; if (o_state !== 2'd3 || o_index !== 4'd0) begin fails++; $display("FAIL step_to_flush: got state %0d index %0d, expected 3 and 0", o_state, o_index); end
        k = 0;
        while (o_sample_stb !== 1'b1 && k < 60) begin
            @(negedge clk_50Hz);
            #1;
            k++;
        end
        tests++; if (o_sample_stb !== 1'b1) begin fails++; $display("FAIL flush_strobe_seen: got %0b, expected 1", o_sample_stb); end
        tests++; if (o_xin !== 3'd0) begin fails++; $display("FAIL flush_xin: got %0d, expected 0", o_xin); end
        i_rst_n = 1'b0;
        #1;
        tests++; if (o_sample_stb !== 1'b0) begin fails++; $display("FAIL abort_stb: got %0b, expected 0", o_sample_stb); end
        tests++; if (o_xin !== 3'd0) begin fails++; $display("FAIL abort_xin: got %0d, expected 0", o_xin); end
        tests++; if (o_state !== 2'd0) begin fails++; $display("FAIL abort_state: got %0d, expected 0", o_state); end
        tests++; if (o_index !== 4'd0) begin fails++; $display("FAIL abort_index: got %0d, expected 0", o_index); end
        repeat (2) @(posedge clk_50Hz);
        #1;
        stb_cyc.delete();
        stb_val.delete();
        model_reset();
        i_rst_n = 1'b1;
        repeat (30) @(posedge clk_50Hz);
        #1;
        tests++; if (stb_cyc.size() != 0 || o_state !== 2'd0) begin fails++; $display("FAIL after_abort_quiet: got %0d strobes state %0d, expected 0 and 0", stb_cyc.size(), o_state); end
        for (int i = 0; i < 2; i++) begin
            press(K_STEP, ev);
            exp = model_emit();
            tests++; if (stb_val.size() != i + 1 || stb_val[stb_val.size() - 1] != exp) begin fails++; $display("FAIL impulse_restored[%0d]: got %0d, expected %0d", i, stb_val[stb_val.size() - 1], exp); end
        end
    endtask

    initial begin
        test_reset();
        test_step_idle();
        test_run_flush();
        test_load_step();
        test_pause_resume();
        test_loop();
        test_reset_flush();
        tests++; if (stb_wide != 0) begin fails++; $display("FAIL strobe_width: got %0d over-long strobes, expected 0", stb_wide); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_sample_sequencer.md
FIR_SAMPLE_SEQUENCER -- requirements
Module: fir_sample_sequencer

Interface
REQ-001 Parameter STEP_DIV, default 25, clk_50Hz cycles per automatic sample (0.5 s).
REQ-002 Parameter FLUSH_LEN, default 8, number of zero samples emitted after a non-looping run.
REQ-003 clk_50Hz  input  1  sequencer clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_key_run_n  input  1  debounced run/pause key level; 0 = pressed.
REQ-006 i_key_step_n  input  1  debounced single-step key level; 0 = pressed.
REQ-007 i_key_load_n  input  1  debounced pattern-load key level; 0 = pressed.
REQ-008 i_loop  input  1  1 = wrap pattern endlessly; 0 = one pass, then flush.
REQ-009 i_manual_x  input  3  sample value written by load.
REQ-010 o_xin  output  3  current sample for FIR core Xin.
REQ-011 o_sample_stb  output  1  one-cycle high pulse; rising edge clocks FIR core.
REQ-012 o_index  output  4  pattern read pointer (next entry to emit).
REQ-013 o_state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 FLUSH.

Function
REQ-014 Each key input passes a 2-flop synchronizer; a press event is a synchronized 1->0 transition, one event per press.
REQ-015 Pattern store: 16 x 3-bit registers; write pointer wr_ptr (4 bit), read pointer rd_ptr (4 bit), both wrap 15->0.
REQ-016 Load event in IDLE: pattern[wr_ptr] <= i_manual_x, wr_ptr++; load event in any other state ignored.
REQ-017 IDLE: run event -> RUN with prescaler cleared; step event -> emit one sample, stay IDLE.
REQ-018 RUN: prescaler counts 0..STEP_DIV-1; at STEP_DIV-1 emit one sample and reload 0; run event -> PAUSE, prescaler held.
REQ-019 PAUSE: run event -> RUN, prescaler resumes from held value; step event -> emit one sample, stay PAUSE.
REQ-020 Emit from pattern: o_xin <= pattern[rd_ptr], rd_ptr++ on the same edge (edge E).
REQ-021 o_sample_stb is high for exactly the cycle between edges E+1 and E+2, so o_xin is stable one full cycle before the strobe rising edge.
REQ-022 Emit of entry 15 with i_loop=0 (RUN, PAUSE step or IDLE step): rd_ptr -> 0 and FSM -> FLUSH after that emission; with i_loop=1, rd_ptr wraps to 0, state unchanged.
REQ-023 FLUSH: emits FLUSH_LEN samples of value 0 at the STEP_DIV cadence, ignores all key events, then -> IDLE with prescaler cleared.
REQ-024 A new emission is never scheduled while a strobe is pending; minimum spacing between strobes is 2 cycles (step events closer than that are dropped).
REQ-025 Run and step events on the same edge: run processed, step dropped; load with run/step on same edge in IDLE: load performed, run processed, step dropped.
REQ-026 o_index always equals rd_ptr; o_state always equals the registered FSM state.

Reset
REQ-027 Asynchronous assertion of i_rst_n=0 forces, within the same instant: state IDLE, o_xin=0, o_sample_stb=0, rd_ptr=0, wr_ptr=0, prescaler=0, flush counter=0, synchronizer flops=1.
REQ-028 Reset pattern contents: entry 0 = 3'd7, entries 1..15 = 0 (unit impulse).
REQ-029 Reset mid-RUN or mid-FLUSH aborts immediately; a strobe in progress is cut low; no emission until a new event after release.
REQ-030 Release is synchronous in effect: first key sampled on the first rising edge after i_rst_n=1.

Verification
REQ-031 Reset, single step press in IDLE -> o_xin=7 one edge after synchronized press, o_sample_stb high next cycle only, o_index=1.
REQ-032 i_loop=0, run press, wait -> 16 strobes spaced 25 cycles (7,0,...,0), then o_state=3, 8 zero strobes, then o_state=0, o_index=0.
REQ-033 Load 3 values 5,2,6 in IDLE, step x3 -> o_xin sequence 5,2,6; load press during RUN -> pattern unchanged.
REQ-034 RUN, run press at prescaler=10, hold 100 cycles, run press -> no strobes while paused; next strobe 15 cycles after resume.
REQ-035 i_loop=1, 40 automatic samples -> o_index wraps 15->0 with no FLUSH entry; run+step same edge -> only state change, no extra strobe.
REQ-036 Assert i_rst_n=0 during FLUSH with strobe high -> o_sample_stb, o_xin, o_state, o_index all 0 immediately; pattern back to impulse.
